// File: rtl/seven_seg_scan_ctrl_if.sv
// Bus between the register/status logic and the seven-segment scan
// controller. The control side drives the display request; the controller
// returns the decoder nibble and the pin-level anode/decimal-point drives.
interface seven_seg_scan_ctrl_if #(
  parameter int NUM_DIGITS = 4
);
  logic                    enable;
  logic                    load;
  logic [4*NUM_DIGITS-1:0] value;
  logic [NUM_DIGITS-1:0]   dp_mask;
  logic                    blank_lz;
  logic [3:0]              digit_sel;
  logic [NUM_DIGITS-1:0]   an;
  logic                    dp_n;
  logic                    frame_done;

  modport master (
    output enable, load, value, dp_mask, blank_lz,
    input  digit_sel, an, dp_n, frame_done
  );

  modport slave (
    input  enable, load, value, dp_mask, blank_lz,
    output digit_sel, an, dp_n, frame_done
  );
endinterface

// File: rtl/seven_seg_scan_ctrl.sv
// Time-multiplexed scan controller for a common-anode seven-segment display.
// One nibble at a time goes to a shared hex decoder while the matching anode
// is pulled low. Each digit slot is a GUARD interval (all anodes off, nibble
// switches) followed by an ON interval. The displayed value lives in a shadow
// register that only changes at a frame boundary, so a frame never tears.
module seven_seg_scan_ctrl #(
  parameter int NUM_DIGITS   = 4,
  parameter int GUARD_CYCLES = 500,
  parameter int ON_CYCLES    = 50000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  seven_seg_scan_ctrl_if.slave   bus
);

  localparam int W    = 4 * NUM_DIGITS;
  localparam int IW   = $clog2(NUM_DIGITS);
  localparam int MAXC = (GUARD_CYCLES > ON_CYCLES) ? GUARD_CYCLES : ON_CYCLES;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

  localparam logic [IW-1:0] LAST_IDX   = IW'(NUM_DIGITS - 1);
  localparam logic [CW-1:0] GUARD_LAST = CW'(GUARD_CYCLES - 1);
  localparam logic [CW-1:0] ON_LAST    = CW'(ON_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, GUARD, ON} state_t;

  state_t                state_q, state_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [W-1:0]          shadow_q, shadow_d;
  logic [W-1:0]          staging_q, staging_d;
  logic                  pending_q, pending_d;

  logic [3:0]            sel_q, sel_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic                  dp_n_q, dp_n_d;
  logic                  frame_done_q, frame_done_d;

  // A digit is blanked when it is not the rightmost one and it and every
  // more-significant nibble are zero.
  function automatic logic lz_blanked(input logic [W-1:0] s,
                                      input logic [IW-1:0] d,
                                      input logic          en);
    logic all_zero;
    all_zero = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (IW'(i) >= d && s[4*i +: 4] != 4'h0) all_zero = 1'b0;
    end
    return en && (d != '0) && all_zero;
  endfunction

  // Next-state logic: scan sequencing, double-buffered value capture.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned, which would infer a latch.
    state_d      = state_q;
    idx_d        = idx_q;
    cnt_d        = cnt_q;
    shadow_d     = shadow_q;
    staging_d    = staging_q;
    pending_d    = pending_q;
    frame_done_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        // Nothing is on screen, so a load can go straight to the shadow and
        // supersedes any older staged value.
        if (bus.load) begin
          shadow_d  = bus.value;
          pending_d = 1'b0;
        end
        if (bus.enable) begin
          state_d = GUARD;
          idx_d   = '0;
          cnt_d   = '0;
        end
      end

      GUARD, ON: begin
        if (bus.load) begin
          staging_d = bus.value;
          pending_d = 1'b1;
        end
        if (!bus.enable) begin
          state_d = IDLE;
          idx_d   = '0;
          cnt_d   = '0;
        end else if (state_q == GUARD) begin
          if (cnt_q == GUARD_LAST) begin
            state_d = ON;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end else if (cnt_q == ON_LAST) begin
          state_d = GUARD;
          cnt_d   = '0;
          if (idx_q == LAST_IDX) begin
            // Frame boundary: the only place the shadow changes while scanning.
            idx_d        = '0;
            frame_done_d = 1'b1;
            if (pending_q || bus.load) begin
              shadow_d = bus.load ? bus.value : staging_q;
            end
            pending_d = 1'b0;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // Output decode from the next state so the registered pins line up with
  // the state register cycle for cycle.
  always_comb begin
    sel_d  = sel_q;
    an_d   = '1;
    dp_n_d = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_d == IW'(i)) begin
        if (state_d == GUARD) sel_d = shadow_d[4*i +: 4];
        if (state_d == ON && !lz_blanked(shadow_d, idx_d, bus.blank_lz)) begin
          an_d[i] = 1'b0;
          dp_n_d  = ~bus.dp_mask[i];
        end
      end
    end
  end

  // State and output registers; reset blanks the display at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      cnt_q        <= '0;
      shadow_q     <= '0;
      staging_q    <= '0;
      pending_q    <= 1'b0;
      sel_q        <= '0;
      an_q         <= '1;
      dp_n_q       <= 1'b1;
      frame_done_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q      <= state_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      shadow_q     <= shadow_d;
      staging_q    <= staging_d;
      pending_q    <= pending_d;
      sel_q        <= sel_d;
      an_q         <= an_d;
      dp_n_q       <= dp_n_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign bus.digit_sel  = sel_q;
  assign bus.an         = an_q;
  assign bus.dp_n       = dp_n_q;
  assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Randomized scoreboard bench for seven_seg_scan_ctrl (4 digits, 2 guard
// cycles, 8 on cycles). A reference model tracks the position within the
// frame arithmetically and queues the expected pins for every clock; a
// monitor compares them on the falling edge.
module tb_seven_seg_scan_ctrl;

  localparam int N     = 4;
  localparam int G     = 2;
  localparam int ONC   = 8;
  localparam int SLOT  = G + ONC;
  localparam int FRAME = N * SLOT;

  typedef struct {
    logic [N-1:0] an;
    logic         dp_n;
    logic [3:0]   sel;
    logic         fd;
  } exp_t;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;
  exp_t q[$];

  // Reference model state.
  bit          m_run;
  int          m_t;
  logic [15:0] m_shadow;
  logic [15:0] m_stage;
  bit          m_pend;
  logic [3:0]  m_sel;

  seven_seg_scan_ctrl_if #(.NUM_DIGITS(N)) sif ();

  seven_seg_scan_ctrl #(
    .NUM_DIGITS  (N),
    .GUARD_CYCLES(G),
    .ON_CYCLES   (ONC)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (sif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, req);
    end
  endtask

  task automatic model_reset();
    m_run    = 0;
    m_t      = 0;
    m_shadow = '0;
    m_stage  = '0;
    m_pend   = 0;
    m_sel    = '0;
  endtask

  // Apply one clock of the current inputs to the model, then queue what the
  // pins must show after that edge.
  task automatic tick();
    exp_t e;
    int   slot;
    int   ph;
    logic fd;
    fd = 1'b0;
    if (!m_run) begin
      if (sif.load) begin
        m_shadow = sif.value;
        m_pend   = 0;
      end
      if (sif.enable) begin
        m_run = 1;
        m_t   = 0;
      end
    end else begin
      if (sif.load) begin
        m_stage = sif.value;
        m_pend  = 1;
      end
      if (!sif.enable) begin
        m_run = 0;
      end else begin
        m_t++;
        if (m_t == FRAME) begin
          m_t = 0;
          fd  = 1'b1;
          if (m_pend) begin
            m_shadow = m_stage;
            m_pend   = 0;
          end
        end
      end
    end
    e.an   = '1;
    e.dp_n = 1'b1;
    e.fd   = fd;
    if (m_run) begin
      slot  = m_t / SLOT;
      ph    = m_t % SLOT;
      m_sel = 4'(m_shadow >> (4 * slot));
      if (ph >= G && !(sif.blank_lz && slot != 0 && (m_shadow >> (4 * slot)) == 0)) begin
        e.an[slot] = 1'b0;
        e.dp_n     = ~sif.dp_mask[slot];
      end
    end
    e.sel = m_sel;
    @(posedge clk);
    q.push_back(e);
    #1;
  endtask

  task automatic load_value(input logic [15:0] v);
    sif.value = v;
    sif.load  = 1'b1;
    tick();
    sif.load  = 1'b0;
  endtask

  // Advance until the model is in the ON part of the given digit slot.
  task automatic wait_slot(input int s);
    bit found;
    found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      if (m_run && m_t / SLOT == s && m_t % SLOT >= G) found = 1;
      else tick();
    end
    check("wait_slot", 32'(found), 32'd1);
  endtask

  // Scoreboard monitor.
  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      check("an", 32'(sif.an), 32'(e.an));
      check("dp_n", 32'(sif.dp_n), 32'(e.dp_n));
      check("digit_sel", 32'(sif.digit_sel), 32'(e.sel));
      check("frame_done", 32'(sif.frame_done), 32'(e.fd));
    end
  end

  initial begin
    n_checks      = 0;
    n_errors      = 0;
    rst_n         = 1'b0;
    sif.enable    = 1'b0;
    sif.load      = 1'b0;
    sif.value     = '0;
    sif.dp_mask   = '0;
    sif.blank_lz  = 1'b0;
    model_reset();

    #12;
    check("reset_an", 32'(sif.an), 32'hF);
    check("reset_dp_n", 32'(sif.dp_n), 32'd1);
    check("reset_digit_sel", 32'(sif.digit_sel), 32'd0);
    check("reset_frame_done", 32'(sif.frame_done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Plain scan of an all-zero shadow, past one frame boundary.
    repeat (3) tick();
    sif.enable = 1'b1;
    repeat (45) tick();

    // Load in IDLE together with enable.
    sif.enable = 1'b0;
    repeat (2) tick();
    sif.enable = 1'b1;
    load_value(16'h12AF);
    repeat (40) tick();

    // Mid-frame load is deferred to the next frame boundary.
    wait_slot(1);
    load_value(16'h0005);
    repeat (80) tick();

    // Two loads in one frame: last one wins.
    wait_slot(1);
    load_value(16'h7C3B);
    wait_slot(3);
    load_value(16'h0A00);
    repeat (80) tick();

    // Leading-zero blanking on and off.
    wait_slot(1);
    load_value(16'h0005);
    sif.blank_lz = 1'b1;
    repeat (90) tick();
    sif.blank_lz = 1'b0;
    repeat (40) tick();

    // Decimal point on digit 2 only.
    sif.dp_mask = 4'b0100;
    repeat (40) tick();
    sif.dp_mask = 4'b0000;

    // Drop enable during digit 2's ON slot, then restart.
    wait_slot(2);
    tick();
    sif.enable = 1'b0;
    repeat (3) tick();
    sif.enable = 1'b1;
    repeat (45) tick();

    // Randomized traffic, biased toward leading zeros.
    repeat (600) begin
      sif.enable   = ($urandom_range(0, 19) != 0);
      sif.load     = ($urandom_range(0, 9) == 0);
      sif.value    = 16'($urandom & (32'hFFFF >> (4 * $urandom_range(0, 4))));
      sif.dp_mask  = 4'($urandom);
      sif.blank_lz = 1'($urandom);
      tick();
    end
    sif.load     = 1'b0;
    sif.dp_mask  = 4'b0000;
    sif.blank_lz = 1'b0;

    // Asynchronous reset in the middle of an ON slot.
    sif.enable = 1'b1;
    load_value(16'hBEEF);
    wait_slot(2);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("async_an", 32'(sif.an), 32'hF);
    check("async_dp_n", 32'(sif.dp_n), 32'd1);
    check("async_digit_sel", 32'(sif.digit_sel), 32'd0);
    check("async_frame_done", 32'(sif.frame_done), 32'd0);
    model_reset();
    sif.enable = 1'b0;
    sif.load   = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Shadow cleared by reset: with blanking only digit 0 lights.
    sif.blank_lz = 1'b1;
    sif.enable   = 1'b1;
    repeat (45) tick();
    sif.enable = 1'b0;
    tick();

    @(negedge clk);
    #1;
    check("queue_drained", 32'(q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
